fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
Output reorder stage directly downstream of the 16-point SDF FFT. The FFT emits y_r/y_im one complex sample per clock in bit-reversed bin order. This block buffers each 16-sample frame in a ping-pong register bank and replays it in natural bin order. Output uses a valid/ready handshake, so downstream consumers (magnitude, UART packer) can stall.

Parameters:
DW, 8, width of each real/imag component
N, 16, points per frame (power of two)
LOGN, 4, log2(N)

Ports:
clk  input  1  system clock, rising edge
clear  input  1  reset, synchronous, active-high
in_valid  input  1  FFT output sample present this cycle (no backpressure to FFT)
in_sof  input  1  first sample of a frame, qualified by in_valid
in_r  input  DW  FFT real output (y_r)
in_im  input  DW  FFT imag output (y_im)
out_valid  output  1  output sample valid
out_ready  input  1  consumer accepts sample
out_r  output  DW  real part, natural order
out_im  output  DW  imag part, natural order
out_idx  output  LOGN  bin index of current output
out_sof  output  1  out_idx==0 marker
out_eof  output  1  out_idx==N-1 marker
overflow  output  1  sticky: a frame was dropped

Behaviour:
- Reset (clear=1 at a clk edge): out_valid, out_r, out_im, out_idx, out_sof, out_eof, overflow all 0. Write counter wcnt=0, wbank=0, rbank=0, both bank-full flags 0, read FSM to IDLE. Bank data is not reset. clear overrides every other input in the same cycle.
- Write side: each cycle with in_valid=1 stores {in_r,in_im} at address bitrev(wcnt) of bank wbank, then wcnt++ (wraps N-1 -> 0).
- in_sof=1 with in_valid=1 forces the sample to wcnt=0. Any partial frame is abandoned silently. Its bank is not marked full.
- Frame drop: if a frame starts (wcnt==0 and in_valid) while full[wbank]=1, all N samples of that frame are discarded. wcnt still advances, overflow is set to 1 and stays 1 until clear.
- Frame commit: at the edge that accepts wcnt==N-1 (not dropped), set full[wbank]=1 and toggle wbank.
- Read FSM states:
  - IDLE: when full[rbank]=1 -> STREAM, rcnt=0.
  - STREAM: the output register loads mem[rbank][rcnt] whenever (!out_valid || out_ready). On the load of rcnt==N-1: clear full[rbank], toggle rbank, then go IDLE, or stay in STREAM with rcnt=0 if the other bank is already full (no bubble).
- Output register: out_r/out_im/out_idx/out_sof/out_eof are held stable while out_valid && !out_ready. A transfer occurs when out_valid && out_ready. out_valid drops after the last transfer if no data is pending.
- Latency: the first output has out_valid=1 in the cycle after the edge following the commit edge (2 edges after the last input sample). With out_ready=1 constantly, N outputs follow on consecutive cycles.
- Simultaneous commit into one bank and release of the other in the same cycle is legal; both flag updates take effect.
- Arithmetic: none; data passes bit-exact. Index bit reversal is pure wiring.

Decomposition:
- Shared package fft_pkg: DW, N, LOGN constants, the packed complex sample type {re,im} of 2*DW bits, and a bitrev(LOGN) function shared with the FFT stages.
- One sub-module, fft_reorder_bank: an N x 2*DW register array with one synchronous write port and one combinational read port. It is instantiated twice for ping/pong.
- FSM, counters and flags live in the top module.

Test Plan:
- Single frame, sample k carries in_r=k, in_im=~k, out_ready=1 -> out_r sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_idx 0..15. out_sof only on the first output, out_eof only on the last. First out_valid 2 edges after the last input.
- Three back-to-back frames, out_ready=1 -> 48 contiguous outputs, no out_valid gaps, overflow=0.
- out_ready=0 for 40 cycles from frame 1 output start while frames 2 and 3 stream in -> frame 3 dropped, overflow=1. Frames 1 and 2 are output intact, with frame 1 resuming at the stalled index.
- in_sof asserted at sample 5 of a frame -> the 5 prior samples are ignored. The next 16 samples form a correct frame. overflow stays 0.
- Random out_ready toggling -> out_r/out_im/out_idx unchanged across every cycle with out_valid=1, out_ready=0. Scoreboard order is correct.
- clear asserted mid-output -> all outputs 0 at the next edge. A new frame after reset outputs correctly with no stale data.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT types and constants: sample width, frame size, complex sample
// layout and the bin-index bit reversal used by the SDF stages.
package fft_pkg;

    localparam int unsigned DW   = 8;
    localparam int unsigned N    = 16;
    localparam int unsigned LOGN = 4;

    typedef logic [LOGN-1:0] idx_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    function automatic idx_t bitrev(input idx_t a);
        return {<<{a}};
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Sample stream from the FFT and natural-order stream to the consumer.
interface fft_bitrev_reorder_if;
    import fft_pkg::*;

    logic            in_valid;
    logic            in_sof;
    logic [DW-1:0]   in_r;
    logic [DW-1:0]   in_im;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_r;
    logic [DW-1:0]   out_im;
    logic [LOGN-1:0] out_idx;
    logic            out_sof;
    logic            out_eof;
    logic            overflow;

    modport master (
        output in_valid, in_sof, in_r, in_im, out_ready,
        input  out_valid, out_r, out_im, out_idx, out_sof, out_eof, overflow
    );

    modport slave (
        input  in_valid, in_sof, in_r, in_im, out_ready,
        output out_valid, out_r, out_im, out_idx, out_sof, out_eof, overflow
    );

endinterface

// File: rtl/fft_reorder_bank.sv
// One frame of complex samples: synchronous write port, combinational read port.
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic  clk,
    input  logic  i_we,
    input  idx_t  i_waddr,
    input  cplx_t i_wdata,
    input  idx_t  i_raddr,
    output cplx_t o_rdata
);

    cplx_t r_mem [N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed bin order and are
// replayed in natural order through a stallable valid/ready output register.
module fft_bitrev_reorder
    import fft_pkg::*;
(
    input logic                 clk,
    input logic                 clear,
    fft_bitrev_reorder_if.slave bus
);

    // write side state
    idx_t       r_wcnt;
    logic       r_wbank;
    logic       r_drop;
    logic [1:0] r_full;
    logic       r_overflow;

    // read side state
    rd_state_t  r_state;
    rd_state_t  w_state_nxt;
    idx_t       r_rcnt;
    idx_t       w_rcnt_nxt;
    logic       r_rbank;
    logic       w_rbank_nxt;

    // output register
    logic       r_out_valid;
    cplx_t      r_out;
    idx_t       r_out_idx;
    logic       r_out_sof;
    logic       r_out_eof;

    idx_t       w_wptr;
    logic       w_frame_start;
    logic       w_bank_busy;
    logic       w_drop;
    logic       w_accept;
    logic       w_commit;
    logic [1:0] w_we;
    logic [1:0] w_release;
    logic       w_load;
    logic       w_last;
    cplx_t      w_wdata;
    cplx_t      w_rdata0;
    cplx_t      w_rdata1;
    cplx_t      w_rsel;

    assign w_wptr        = (bus.in_valid && bus.in_sof) ? '0 : r_wcnt;
    assign w_frame_start = bus.in_valid && (w_wptr == '0);
    // A bank the reader frees on this very edge counts as empty, so a frame
    // that starts right behind the previous one is not dropped.
    assign w_bank_busy   = r_full[r_wbank] && !w_release[r_wbank];
    assign w_drop        = w_frame_start ? w_bank_busy : r_drop;
    assign w_accept      = bus.in_valid && !w_drop;
    assign w_commit      = w_accept && (w_wptr == '1);
    assign w_we          = {w_accept && r_wbank, w_accept && !r_wbank};
    assign w_wdata       = '{re: bus.in_r, im: bus.in_im};

    assign w_load    = (r_state == RD_STREAM) && (!r_out_valid || bus.out_ready);
    assign w_last    = w_load && (r_rcnt == '1);
    assign w_release = {w_last && r_rbank, w_last && !r_rbank};
    assign w_rsel    = r_rbank ? w_rdata1 : w_rdata0;

    fft_reorder_bank u_bank0 (
        .clk     (clk),
        .i_we    (w_we[0]),
        .i_waddr (bitrev(w_wptr)),
        .i_wdata (w_wdata),
        .i_raddr (r_rcnt),
        .o_rdata (w_rdata0)
    );

    fft_reorder_bank u_bank1 (
        .clk     (clk),
        .i_we    (w_we[1]),
        .i_waddr (bitrev(w_wptr)),
        .i_wdata (w_wdata),
        .i_raddr (r_rcnt),
        .o_rdata (w_rdata1)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_rbank_nxt = r_rbank;
        case (r_state)
            RD_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_state_nxt = RD_STREAM;
                    w_rcnt_nxt  = '0;
                end
            end
            RD_STREAM: begin
                if (w_last) begin
                    w_rbank_nxt = !r_rbank;
                    w_rcnt_nxt  = '0;
                    if (!r_full[!r_rbank]) begin
                        w_state_nxt = RD_IDLE;
                    end
                end else if (w_load) begin
                    w_rcnt_nxt = r_rcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_wcnt     <= '0;
            r_wbank    <= 1'b0;
            r_drop     <= 1'b0;
            r_full     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                r_wcnt <= w_wptr + 1'b1;
                r_drop <= w_drop;
            end
            if (w_commit) begin
                r_wbank <= !r_wbank;
            end
            if (w_frame_start && w_bank_busy) begin
                r_overflow <= 1'b1;
            end
            r_full <= (r_full & ~w_release) | (w_commit ? {r_wbank, !r_wbank} : 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= RD_IDLE;
            r_rcnt      <= '0;
            r_rbank     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_idx   <= '0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_rbank <= w_rbank_nxt;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out       <= w_rsel;
                r_out_idx   <= r_rcnt;
                r_out_sof   <= (r_rcnt == '0);
                r_out_eof   <= (r_rcnt == '1);
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_r     = r_out.re;
    assign bus.out_im    = r_out.im;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_sof   = r_out_sof;
    assign bus.out_eof   = r_out_eof;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the bit-reversal reorder stage with an output scoreboard.
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic clear;

    fft_bitrev_reorder_if bus ();

    fft_bitrev_reorder dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // natural bin j holds input sample BR[j]
    localparam logic [3:0] BR [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                       4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] held;
    logic        prev_stall = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic v, input logic [7:0] r, input logic [7:0] im,
                                       input logic [3:0] idx, input logic sof, input logic eof);
        return {v, 9'd0, r, im, idx, sof, eof};
    endfunction

    function automatic logic [31:0] obs_word();
        return pk(bus.out_valid, bus.out_r, bus.out_im, bus.out_idx, bus.out_sof, bus.out_eof);
    endfunction

    task automatic push_frame(input logic [7:0] base);
        logic [7:0] v;
        for (int j = 0; j < 16; j++) begin
            v = base + {4'd0, BR[j]};
            exp_q.push_back(pk(1'b1, v, ~v, 4'(j), j == 0, j == 15));
        end
    endtask

    task automatic send_frame(input logic [7:0] base);
        logic [7:0] v;
        for (int k = 0; k < 16; k++) begin
            v = base + 8'(k);
            bus.in_valid = 1'b1;
            bus.in_sof   = (k == 0);
            bus.in_r     = v;
            bus.in_im    = ~v;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned c = 0;
        while (bus.out_valid !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq("wait_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        int unsigned c = 0;
        while ((exp_q.size() != 0 || bus.out_valid !== 1'b0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_idle"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    // scoreboard on every transfer, stability check on every stalled cycle
    always @(negedge clk) begin
        if (prev_stall) begin
            check_eq("hold", obs_word(), held);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq("out_data", obs_word(), exp_q.pop_front());
            end
        end
        prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0) && (clear !== 1'b1);
        held       = obs_word();
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not end, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        clear         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_r      = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out", obs_word(), 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        clear = 1'b0;
        @(posedge clk); #1;

        // single frame, latency of two edges after the last input
        push_frame(8'h00);
        send_frame(8'h00);
        @(negedge clk); check_eq("lat_e0", 32'(bus.out_valid), 32'd0);
        @(negedge clk); check_eq("lat_e1", 32'(bus.out_valid), 32'd0);
        @(negedge clk); check_eq("lat_e2", 32'(bus.out_valid), 32'd1);
        drain("single", 100);

        // three back-to-back frames stream out without bubbles
        push_frame(8'h10);
        push_frame(8'h30);
        push_frame(8'h50);
        fork
            begin
                send_frame(8'h10);
                send_frame(8'h30);
                send_frame(8'h50);
            end
            begin
                wait_valid(60);
                for (int i = 0; i < 48; i++) begin
                    check_eq("contig", 32'(bus.out_valid), 32'd1);
                    @(negedge clk);
                end
                check_eq("contig_end", 32'(bus.out_valid), 32'd0);
            end
        join
        check_eq("ovf_b2b", 32'(bus.overflow), 32'd0);
        drain("b2b", 100);

        // consumer stalls, third frame finds both banks full
        bus.out_ready = 1'b0;
        push_frame(8'h60);
        push_frame(8'h80);
        fork
            begin
                send_frame(8'h60);
                send_frame(8'h80);
                send_frame(8'hA0);
            end
            begin
                wait_valid(60);
                repeat (40) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        check_eq("ovf_drop", 32'(bus.overflow), 32'd1);
        drain("stall", 200);
        check_eq("ovf_sticky", 32'(bus.overflow), 32'd1);

        // clear in the middle of an output frame
        push_frame(8'h20);
        send_frame(8'h20);
        repeat (6) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_eq("clear_out", obs_word(), 32'd0);
        check_eq("clear_ovf", 32'(bus.overflow), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;

        // in_sof on sample 5 abandons the partial frame
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sof   = 1'b0;
            bus.in_r     = 8'hE0 + 8'(k);
            bus.in_im    = 8'h5A;
            @(posedge clk); #1;
        end
        push_frame(8'h40);
        send_frame(8'h40);
        drain("resync", 100);
        check_eq("ovf_resync", 32'(bus.overflow), 32'd0);

        // random backpressure
        push_frame(8'hC0);
        push_frame(8'hD0);
        fork
            begin
                send_frame(8'hC0);
                send_frame(8'hD0);
            end
            begin
                repeat (120) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("random", 200);
        check_eq("ovf_random", 32'(bus.overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
